// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer
//   Walks a KxK window over every output pixel of an iw x ih image and streams
//   the taps, in order, to the XNOR/popcount datapath. In-bounds taps cost one
//   word read from the image memory. Padded taps are emitted as zero without
//   touching memory.
//   Loop order, outer to inner: j (row), i (col), wj, wi. Window offsets run
//   from -PAD to +PAD, where PAD = (K-1)/2.
// Ports
//   clk_i / rst_i            clock, async active-high reset
//   start_i                  job start, honoured only while idle
//   iw_i, ih_i, base_addr_i  job config, latched at start
//   busy_o, done_o           job in progress / one-cycle completion pulse
//   mem_req_o, mem_addr_o    read request, address held until mem_gnt_i
//   mem_gnt_i                read request accepted
//   mem_rvalid_i, mem_rdata_i  read response
//   out_valid_o, out_data_o, out_last_o, out_ready_i
//                            tap stream; out_last_o marks the last tap of a window
module conv_window_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int K      = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [15:0]       iw_i,
  input  logic [15:0]       ih_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i
);

  localparam int PAD = (K - 1) / 2;
  localparam logic signed [17:0] PAD_S  = 18'(PAD);
  localparam logic signed [17:0] NPAD_S = -PAD_S;

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_WAIT, S_EMIT, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [15:0]           iw_q, iw_d, ih_q, ih_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [15:0]           i_q, i_d, j_q, j_d;
  logic signed [17:0]    wi_q, wi_d, wj_q, wj_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  req_q, req_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic                  valid_q, valid_d, last_q, last_d;
  logic                  done_q, done_d, busy_q, busy_d;

  // Tap geometry for the current counter values
  logic signed [17:0]    x, y;
  logic                  pad, win_last, final_tap;
  logic [31:0]           lin;
  logic [ADDR_W-1:0]     tap_addr;

  always_comb begin
    x         = $signed({2'b00, i_q}) + wi_q;
    y         = $signed({2'b00, j_q}) + wj_q;
    pad       = x[17] | y[17] | (x >= $signed({2'b00, iw_q})) | (y >= $signed({2'b00, ih_q}));
    // Only used when not padded, so x and y are non-negative and fit in 16 bits.
    // The largest value, 65535*65535 + 65535, still fits in 32 bits.
    lin       = 32'(y[15:0]) * 32'(iw_q) + 32'(x[15:0]);
    tap_addr  = base_q + ADDR_W'(lin);
    win_last  = (wi_q == PAD_S) && (wj_q == PAD_S);
    final_tap = win_last && (i_q == iw_q - 16'd1) && (j_q == ih_q - 16'd1);
  end

  always_comb begin
    state_d = state_q;
    iw_d    = iw_q;
    ih_d    = ih_q;
    base_d  = base_q;
    i_d     = i_q;
    j_d     = j_q;
    wi_d    = wi_q;
    wj_d    = wj_q;
    addr_d  = addr_q;
    req_d   = req_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          iw_d   = iw_i;
          ih_d   = ih_i;
          base_d = base_addr_i;
          i_d    = '0;
          j_d    = '0;
          wi_d   = NPAD_S;
          wj_d   = NPAD_S;
          state_d = (iw_i == 16'd0 || ih_i == 16'd0) ? S_DONE : S_CHECK;
        end
      end
      S_CHECK: begin
        if (pad) begin
          data_d  = '0;
          valid_d = 1'b1;
          last_d  = win_last;
          state_d = S_EMIT;
        end else begin
          addr_d  = tap_addr;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_gnt_i) begin
          req_d   = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          data_d  = mem_rdata_i;
          valid_d = 1'b1;
          last_d  = win_last;
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          data_d  = '0;
          // Odometer step: wi is the fastest digit, then wj, then i, then j
          if (wi_q != PAD_S) begin
            wi_d = wi_q + 18'sd1;
          end else begin
            wi_d = NPAD_S;
            if (wj_q != PAD_S) begin
              wj_d = wj_q + 18'sd1;
            end else begin
              wj_d = NPAD_S;
              if (i_q != iw_q - 16'd1) begin
                i_d = i_q + 16'd1;
              end else begin
                i_d = '0;
                j_d = j_q + 16'd1;
              end
            end
          end
          state_d = final_tap ? S_DONE : S_CHECK;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // done_o is registered from the DONE state, so it shows in the cycle after DONE
    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      iw_q    <= '0;
      ih_q    <= '0;
      base_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      wi_q    <= '0;
      wj_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iw_q    <= iw_d;
      ih_q    <= ih_d;
      base_q  <= base_d;
      i_q     <= i_d;
      j_q     <= j_d;
      wi_q    <= wi_d;
      wj_q    <= wj_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign mem_req_o   = req_q;
  assign mem_addr_o  = addr_q;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

endmodule
